uart_transmitter: RTL

Byte-serial UART transmitter, the transmit-side counterpart of the design's UART receiver. It accepts bytes over a valid/ready handshake into a small FIFO and serializes each byte onto TxD as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit. It sits between game logic that issues commands or scores and the board's USB-UART bridge.

---
 rtl/uart_transmitter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: valid/ready byte intake into a circular FIFO,
// serialized LSB first on TxD with back-to-back frames and no idle gap.
module uart_transmitter #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        TxD,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
   localparam int CW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW        = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            push;
   logic            pop;
   logic            bit_end;
   logic            fifo_nonempty;

   // tx_ready looks only at the registered count, so a full FIFO stays closed
   // even on a cycle where a pop is draining it.
   assign tx_ready      = !reset && (fifo_count != NW'(FIFO_DEPTH));
   assign push          = tx_valid && tx_ready;
   assign fifo_nonempty = (fifo_count != '0);
   assign bit_end       = (baud_cnt == CW'(BIT_TICKS - 1));
   assign pop           = fifo_nonempty && ((state == IDLE) || ((state == STOP) && bit_end));
   assign busy          = (state != IDLE) || fifo_nonempty;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + NW'(1);
            2'b01:   fifo_count <= fifo_count - NW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         TxD      <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               TxD <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  TxD      <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  TxD      <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     TxD   <= 1'b1;
                     state <= STOP;
                  end else begin
                     TxD <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  // Chain straight into the next start bit when bytes are waiting.
                  if (pop) begin
                     shift   <= mem[rd_ptr];
                     bit_idx <= '0;
                     TxD     <= 1'b0;
                     state   <= START;
                  end else begin
                     TxD   <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: begin
               TxD   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
